v2v_vector_loader: RTL
======================

Name: v2v_vector_loader

Overview:
Upstream feeder for the serial dot-product stage (V2V/PE).
- Accepts element pairs (a_i, b_i) one per handshake and packs them into two flat DIMENSION*WIDTH vectors.
- Drives the stage's enable for exactly DIMENSION cycles while holding the vectors stable, captures the WIDTH-bit result, and presents it on a valid/ready output.
- Serialises element streams from memory or an upstream layer into back-to-back dot-product jobs.

Parameters:
DIMENSION, 16, elements per vector; legal range 1..32 (dot-product stage counter is 5 bits)
WIDTH, 8, bits per element and per result
PE_LAT, 1, clock edges after the last en-sampled edge at which vv holds the final sum; must be >= 1

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
s_valid  in  1  element pair valid
s_ready  out  1  loader accepts element pair
s_a  in  WIDTH  element of vector A (signed)
s_b  in  WIDTH  element of vector B (signed)
s_last  in  1  final element of this job (early termination allowed)
V1  out  DIMENSION*WIDTH  packed vector A; lane i at bits [(i+1)*WIDTH-1 : i*WIDTH]
V2  out  DIMENSION*WIDTH  packed vector B, same packing
en  out  1  enable to dot-product stage, registered
vv  in  WIDTH  result from dot-product stage
r_valid  out  1  result valid
r_ready  in  1  result consumer ready
r_data  out  WIDTH  captured dot-product result (signed, wraps modulo 2^WIDTH)

Behaviour:
- Reset (rst=0 at an edge): state LOAD, idx=0, V1=V2=0, en=0, r_valid=0, r_data=0, counters 0. Reset takes priority over everything. Reset mid-RUN/DRAIN aborts the job; en is low from the next cycle.
- s_ready = (state==LOAD) combinationally; 1 in the first cycle after reset. A handshake occurs when s_valid & s_ready at an edge.
- State LOAD:
  - Each handshake writes s_a/s_b into lane idx of V1/V2 and increments idx.
  - If s_last=1 or idx==DIMENSION-1 at the handshake, go to RUN, set en<=1 and clear the run counter.
  - Lanes not written in this job stay 0 (zero-padded).
  - s_valid gaps are allowed; idx holds.
  - s_last on the first element gives a 1-element job.
- State RUN:
  - en=1 for exactly DIMENSION consecutive cycles. V1/V2 are frozen.
  - The run counter counts 0..DIMENSION-1. At the edge where it equals DIMENSION-1, set en<=0 and go to DRAIN.
  - All DIMENSION lanes are always run, including zero pads.
- State DRAIN:
  - Wait PE_LAT edges with en=0.
  - At the PE_LAT-th edge: r_data<=vv, r_valid<=1, go to HOLD.
- State HOLD:
  - r_valid=1; r_data is stable.
  - On r_valid & r_ready: r_valid<=0, V1<=0, V2<=0, idx<=0, go to LOAD.
  - No new elements are accepted until then.
- Timing: let E be the edge accepting the final element. en is high during the DIMENSION cycles after edges E..E+DIMENSION-1. r_valid rises at edge E+DIMENSION+PE_LAT. r_ready=1 at that edge is not a handshake, since r_valid is not yet set.
- Min job period = elements + DIMENSION + PE_LAT + 1 edges. en is low for >= PE_LAT+1 cycles between jobs, which guarantees the stage counter/accumulator clears.
- s_last asserted with idx at DIMENSION-1 is the normal case. Elements beyond DIMENSION cannot occur because the job commits at lane DIMENSION-1.
- No combinational path from s_valid or r_ready to any output except through the registered state.

Test Plan:
1. DIMENSION=16, PE_LAT=1; a=1..16, b=all 1, s_valid held high, s_last on element 16 -> V1 lane i = i+1; en high exactly 16 cycles; r_valid at E+17; r_data=0x88 (136 wraps to -120 signed); r_ready=1 returns to LOAD, s_ready=1 next cycle.
2. Early s_last after 3 elements a={2,3,4}, b={5,6,7} -> lanes 3..15 of V1/V2 = 0; en still 16 cycles; r_data=56 (0x38).
3. Backpressure: r_ready=0 for 5 cycles after r_valid, s_valid=1 throughout -> r_valid and r_data stable, s_ready=0, no element accepted; release -> next job starts cleanly with lane 0.
4. Random s_valid gaps (50% duty) with a=-1 all lanes, b=2 all lanes -> same V1/V2 as gapless load; r_data=0xE0 (-32).
5. rst=0 asserted at the 8th cycle of RUN -> next cycle en=0, V1=V2=0, r_valid=0, s_ready=1; a following full job produces the correct result.
6. Two back-to-back jobs (r_ready tied 1) -> en low for >= 2 cycles between runs; each r_data matches its own vectors, with no accumulation carried over.

Source files
------------

// File: rtl/v2v_vector_loader.sv
// v2v_vector_loader
// Collects element pairs (a_i, b_i) into two packed vectors, enables the
// serial dot-product stage for exactly DIMENSION cycles with the vectors held
// stable, captures the stage result PE_LAT edges later and presents it on a
// valid/ready port. Sequence per job: LOAD -> RUN -> DRAIN -> HOLD -> LOAD.
module v2v_vector_loader #(
  parameter int DIMENSION = 16,
  parameter int WIDTH     = 8,
  parameter int PE_LAT    = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [WIDTH-1:0]           s_a,
  input  logic [WIDTH-1:0]           s_b,
  input  logic                       s_last,
  output logic [DIMENSION*WIDTH-1:0] V1,
  output logic [DIMENSION*WIDTH-1:0] V2,
  output logic                       en,
  input  logic [WIDTH-1:0]           vv,
  output logic                       r_valid,
  input  logic                       r_ready,
  output logic [WIDTH-1:0]           r_data
);

  // Lane index / run counter width, and drain counter width (at least 1 bit).
  localparam int CW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
  localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [CW-1:0] LAST_LANE  = CW'(DIMENSION - 1);
  localparam logic [DW-1:0] LAST_DRAIN = DW'(PE_LAT - 1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CW-1:0]              r_idx;
  logic [CW-1:0]              r_run_cnt;
  logic [DW-1:0]              r_drain_cnt;
  logic                       r_en;
  logic [DIMENSION*WIDTH-1:0] r_v1;
  logic [DIMENSION*WIDTH-1:0] r_v2;
  logic                       r_res_valid;
  logic [WIDTH-1:0]           r_res_data;
  logic                       w_accept;
  logic                       w_release;

  // State register; synchronous active-low reset wins over everything.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create simulation order races.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= LOAD;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic: commit on last/full lane, fixed-length run and drain.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LOAD:    if (w_accept && (s_last || (r_idx == LAST_LANE))) w_state_nxt = RUN;
      RUN:     if (r_run_cnt == LAST_LANE) w_state_nxt = DRAIN;
      DRAIN:   if (r_drain_cnt == LAST_DRAIN) w_state_nxt = HOLD;
      HOLD:    if (w_release) w_state_nxt = LOAD;
      default: w_state_nxt = LOAD;
    endcase
  end

  // Output decode: ready depends only on the registered state.
  always_comb begin
    s_ready   = (r_state == LOAD);
    w_accept  = s_valid && (r_state == LOAD);
    w_release = r_ready && (r_state == HOLD);
  end

  // Datapath: lane packing, counters, stage enable and result capture.
  // NOTE: V1/V2 are plain registers, not a RAM, so they are reset: unwritten
  // lanes of a short job must read as zero and run as zero pads.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx       <= '0;
      r_run_cnt   <= '0;
      r_drain_cnt <= '0;
      r_en        <= 1'b0;
      r_v1        <= '0;
      r_v2        <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else begin
      r_en <= (w_state_nxt == RUN);
      case (r_state)
        LOAD: begin
          r_run_cnt <= '0;
          if (w_accept) begin
            for (int i = 0; i < DIMENSION; i++) begin
              if (r_idx == CW'(i)) begin
                r_v1[i*WIDTH +: WIDTH] <= s_a;
                r_v2[i*WIDTH +: WIDTH] <= s_b;
              end
            end
            r_idx <= r_idx + 1'b1;
          end
        end
        RUN: begin
          r_run_cnt   <= r_run_cnt + 1'b1;
          r_drain_cnt <= '0;
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt + 1'b1;
          if (w_state_nxt == HOLD) begin
            r_res_data  <= vv;
            r_res_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (w_release) begin
            r_res_valid <= 1'b0;
            r_v1        <= '0;
            r_v2        <= '0;
            r_idx       <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign V1      = r_v1;
  assign V2      = r_v2;
  assign en      = r_en;
  assign r_valid = r_res_valid;
  assign r_data  = r_res_data;

endmodule
